// File: rtl/fetch_stage.sv
// Instruction fetch stage: single-outstanding memory requests, IF/ID register,
// one-entry hold buffer for stalls, redirect/trap/return and halt handling.
module fetch_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_target,
  input  logic        halt,
  input  logic        siic,
  input  logic        rti,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic [15:0] Instruction,
  output logic [15:0] PC_plus_two,
  output logic        instr_valid,
  output logic        err
);

  localparam logic [15:0] NOP_INSTR = 16'h0800;
  localparam logic [15:0] TRAP_VEC  = 16'h0002;

  typedef enum logic [1:0] {
    ISSUE  = 2'd0,
    WAIT   = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t      state;
  logic [15:0] pc;
  logic [15:0] epc;
  logic [15:0] hold_instr;
  logic [15:0] hold_pc2;
  logic        hold_valid;
  logic        drop;
  logic        halting;
  logic        post_rst;

  logic        take_redirect;
  logic [15:0] target;
  logic [15:0] pc_next2;
  logic        err_cond;

  function automatic logic rdata_unknown(input logic [15:0] d);
    return ((^d) !== 1'b0) && ((^d) !== 1'b1);
  endfunction

  // siic outranks rti when both are raised; that combination is also flagged as err
  always_comb begin
    take_redirect = 1'b0;
    target        = redirect_target;
    if (siic) begin
      take_redirect = 1'b1;
      target        = TRAP_VEC;
    end else if (rti) begin
      take_redirect = 1'b1;
      target        = epc;
    end else if (redirect) begin
      take_redirect = 1'b1;
      target        = redirect_target;
    end else begin
      take_redirect = 1'b0;
      target        = redirect_target;
    end
  end

  assign pc_next2 = pc + 16'd2;
  // an ack landing in the first cycle after reset belongs to the abandoned request
  assign err_cond = (imem_ack && ((!imem_req && !post_rst) || rdata_unknown(imem_rdata)))
                  || (siic && rti);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ISSUE;
      pc          <= 16'h0000;
      epc         <= 16'h0000;
      imem_req    <= 1'b0;
      imem_addr   <= 16'h0000;
      Instruction <= NOP_INSTR;
      PC_plus_two <= 16'h0000;
      instr_valid <= 1'b0;
      hold_instr  <= 16'h0000;
      hold_pc2    <= 16'h0000;
      hold_valid  <= 1'b0;
      drop        <= 1'b0;
      halting     <= 1'b0;
      post_rst    <= 1'b1;
      err         <= 1'b0;
    end else begin
      post_rst <= 1'b0;
      if (err_cond) err <= 1'b1;
      if (siic && (state != HALTED)) epc <= PC_plus_two;
      case (state)
        ISSUE: begin
          if (take_redirect) begin
            pc          <= target;
            Instruction <= NOP_INSTR;
            instr_valid <= 1'b0;
            hold_valid  <= 1'b0;
          end else if (halt || halting) begin
            Instruction <= NOP_INSTR;
            instr_valid <= 1'b0;
            hold_valid  <= 1'b0;
            state       <= HALTED;
          end else if (hold_valid) begin
            if (!stall) begin
              Instruction <= hold_instr;
              PC_plus_two <= hold_pc2;
              instr_valid <= 1'b1;
              hold_valid  <= 1'b0;
            end
          end else begin
            imem_req  <= 1'b1;
            imem_addr <= pc;
            state     <= WAIT;
            if (!stall) begin
              Instruction <= NOP_INSTR;
              instr_valid <= 1'b0;
            end
          end
        end
        WAIT: begin
          if (take_redirect || halt) begin
            // the request must still complete; its data is thrown away
            if (take_redirect) pc <= target;
            else halting <= 1'b1;
            Instruction <= NOP_INSTR;
            instr_valid <= 1'b0;
            hold_valid  <= 1'b0;
            if (imem_ack) begin
              imem_req <= 1'b0;
              drop     <= 1'b0;
              state    <= (halt && !take_redirect) ? HALTED : ISSUE;
            end else begin
              drop <= 1'b1;
            end
          end else if (imem_ack) begin
            imem_req <= 1'b0;
            drop     <= 1'b0;
            state    <= halting ? HALTED : ISSUE;
            if (drop || halting) begin
              if (!stall) begin
                Instruction <= NOP_INSTR;
                instr_valid <= 1'b0;
              end
            end else if (stall) begin
              hold_instr <= imem_rdata;
              hold_pc2   <= pc_next2;
              hold_valid <= 1'b1;
              pc         <= pc_next2;
            end else begin
              Instruction <= imem_rdata;
              PC_plus_two <= pc_next2;
              instr_valid <= 1'b1;
              pc          <= pc_next2;
            end
          end else if (!stall) begin
            Instruction <= NOP_INSTR;
            instr_valid <= 1'b0;
          end
        end
        HALTED: begin
          imem_req    <= 1'b0;
          Instruction <= NOP_INSTR;
          instr_valid <= 1'b0;
          hold_valid  <= 1'b0;
        end
        default: begin
          state       <= ISSUE;
          imem_req    <= 1'b0;
          Instruction <= NOP_INSTR;
          instr_valid <= 1'b0;
          hold_valid  <= 1'b0;
          drop        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a simple memory model serves requests and
// expected IF/ID contents are queued when responses are driven.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_target;
  logic        halt;
  logic        siic;
  logic        rti;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic [15:0] Instruction;
  logic [15:0] PC_plus_two;
  logic        instr_valid;
  logic        err;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];

  fetch_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
    .redirect_target(redirect_target), .halt(halt), .siic(siic), .rti(rti),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .Instruction(Instruction), .PC_plus_two(PC_plus_two),
    .instr_valid(instr_valid), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_data(input logic [15:0] a);
    return a ^ 16'hC3A5;
  endfunction

  task automatic wait_req();
    int n = 0;
    while (imem_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (imem_req !== 1'b1) begin
      checks++; errors++;
      $display("FAIL req_timeout imem_req=%b required 1", imem_req);
    end
  endtask

  // zero-wait response in the first cycle the request is seen
  task automatic serve(input logic [15:0] exp_addr, input bit push, output logic [15:0] got);
    wait_req();
    got        = imem_addr;
    imem_ack   = 1'b1;
    imem_rdata = mem_data(imem_addr);
    if (push) exp_q.push_back({mem_data(exp_addr), exp_addr + 16'd2});
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = 16'h0000;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_target = 16'h0000;
    halt = 1'b0; siic = 1'b0; rti = 1'b0; imem_ack = 1'b0; imem_rdata = 16'h0000;
    repeat (3) @(negedge clk);
    checks++;
    if ({imem_req, imem_addr, Instruction, PC_plus_two, instr_valid, err} !==
        {1'b0, 16'h0000, 16'h0800, 16'h0000, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state got req=%b addr=%h ins=%h pc2=%h v=%b err=%b required 0/0000/0800/0000/0/0",
               imem_req, imem_addr, Instruction, PC_plus_two, instr_valid, err);
    end
    rst = 1'b0;
  endtask

  task automatic test_zero_wait();
    logic [15:0] got;
    logic [31:0] e;
    for (int i = 0; i < 3; i++) begin
      serve(16'(2 * i), 1'b1, got);
      checks++;
      if (got !== 16'(2 * i)) begin
        errors++; $display("FAIL zw_addr%0d got %h required %h", i, got, 16'(2 * i));
      end
      e = (exp_q.size() == 0) ? 32'hFFFF_FFFF : exp_q.pop_front();
      checks++;
      if ({Instruction, PC_plus_two, instr_valid} !== {e, 1'b1}) begin
        errors++;
        $display("FAIL zw_out%0d got %h/%h/%b required %h/%h/1", i, Instruction, PC_plus_two, instr_valid, e[31:16], e[15:0]);
      end
      checks++;
      if (imem_req !== 1'b0) begin
        errors++; $display("FAIL zw_req_drop%0d got %b required 0", i, imem_req);
      end
    end
  endtask

  task automatic test_stall_hold();
    logic [31:0] e;
    wait_req();
    checks++;
    if (imem_addr !== 16'h0006) begin
      errors++; $display("FAIL hold_addr got %h required 0006", imem_addr);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if ({imem_req, imem_addr} !== {1'b1, 16'h0006}) begin
        errors++; $display("FAIL hold_req_stable%0d got %b/%h required 1/0006", k, imem_req, imem_addr);
      end
    end
    imem_ack = 1'b1; imem_rdata = mem_data(16'h0006); stall = 1'b1;
    exp_q.push_back({mem_data(16'h0006), 16'h0008});
    @(negedge clk);
    imem_ack = 1'b0;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({imem_req, instr_valid, Instruction} !== {1'b0, 1'b0, 16'h0800}) begin
        errors++;
        $display("FAIL hold_stalled%0d got req=%b v=%b ins=%h required 0/0/0800", k, imem_req, instr_valid, Instruction);
      end
      if (k == 0) @(negedge clk);
    end
    stall = 1'b0;
    @(negedge clk);
    e = (exp_q.size() == 0) ? 32'hFFFF_FFFF : exp_q.pop_front();
    checks++;
    if ({Instruction, PC_plus_two, instr_valid} !== {e, 1'b1}) begin
      errors++;
      $display("FAIL hold_release got %h/%h/%b required %h/%h/1", Instruction, PC_plus_two, instr_valid, e[31:16], e[15:0]);
    end
  endtask

  task automatic test_redirect_wait();
    logic [15:0] got;
    logic [31:0] e;
    wait_req();
    redirect = 1'b1; redirect_target = 16'h0010;
    @(negedge clk);
    redirect = 1'b0;
    imem_ack = 1'b1; imem_rdata = mem_data(16'h0008);
    @(negedge clk);
    imem_ack = 1'b0;
    wait_req();
    checks++;
    if (imem_addr !== 16'h0010) begin
      errors++; $display("FAIL redir_addr10 got %h required 0010", imem_addr);
    end
    redirect = 1'b1; redirect_target = 16'h0100;
    @(negedge clk);
    redirect = 1'b0;
    checks++;
    if ({imem_req, imem_addr} !== {1'b1, 16'h0010}) begin
      errors++; $display("FAIL redir_req_kept got %b/%h required 1/0010", imem_req, imem_addr);
    end
    imem_ack = 1'b1; imem_rdata = mem_data(16'h0010);
    @(negedge clk);
    imem_ack = 1'b0;
    checks++;
    if ({Instruction, instr_valid} !== {16'h0800, 1'b0}) begin
      errors++; $display("FAIL redir_discard got %h/%b required 0800/0", Instruction, instr_valid);
    end
    serve(16'h0100, 1'b1, got);
    checks++;
    if (got !== 16'h0100) begin
      errors++; $display("FAIL redir_new_addr got %h required 0100", got);
    end
    e = (exp_q.size() == 0) ? 32'hFFFF_FFFF : exp_q.pop_front();
    checks++;
    if ({Instruction, PC_plus_two, instr_valid} !== {e, 1'b1}) begin
      errors++;
      $display("FAIL redir_out got %h/%h/%b required %h/%h/1", Instruction, PC_plus_two, instr_valid, e[31:16], e[15:0]);
    end
  endtask

  task automatic test_siic_rti();
    logic [15:0] got;
    logic [31:0] e;
    logic [15:0] addrs[3] = '{16'h0022, 16'h0002, 16'h0024};
    redirect = 1'b1; redirect_target = 16'h0022;
    @(negedge clk);
    redirect = 1'b0;
    for (int i = 0; i < 3; i++) begin
      serve(addrs[i], 1'b1, got);
      checks++;
      if (got !== addrs[i]) begin
        errors++; $display("FAIL trap_addr%0d got %h required %h", i, got, addrs[i]);
      end
      e = (exp_q.size() == 0) ? 32'hFFFF_FFFF : exp_q.pop_front();
      checks++;
      if ({Instruction, PC_plus_two, instr_valid} !== {e, 1'b1}) begin
        errors++;
        $display("FAIL trap_out%0d got %h/%h/%b required %h/%h/1", i, Instruction, PC_plus_two, instr_valid, e[31:16], e[15:0]);
      end
      if (i == 0) siic = 1'b1;
      if (i == 1) rti = 1'b1;
      if (i < 2) begin
        @(negedge clk);
        siic = 1'b0; rti = 1'b0;
      end
    end
    checks++;
    if (err !== 1'b0) begin
      errors++; $display("FAIL trap_no_err got %b required 0", err);
    end
  endtask

  task automatic test_wrap();
    logic [15:0] got;
    logic [31:0] e;
    redirect = 1'b1; redirect_target = 16'hFFFE;
    @(negedge clk);
    redirect = 1'b0;
    serve(16'hFFFE, 1'b1, got);
    e = (exp_q.size() == 0) ? 32'hFFFF_FFFF : exp_q.pop_front();
    checks++;
    if ({Instruction, PC_plus_two, instr_valid} !== {e, 1'b1}) begin
      errors++;
      $display("FAIL wrap_out got %h/%h/%b required %h/%h/1", Instruction, PC_plus_two, instr_valid, e[31:16], e[15:0]);
    end
    serve(16'h0000, 1'b0, got);
    checks++;
    if (got !== 16'h0000) begin
      errors++; $display("FAIL wrap_next_addr got %h required 0000", got);
    end
  endtask

  task automatic test_halt();
    wait_req();
    halt = 1'b1;
    @(negedge clk);
    halt = 1'b0;
    checks++;
    if (instr_valid !== 1'b0) begin
      errors++; $display("FAIL halt_bubble got %b required 0", instr_valid);
    end
    imem_ack = 1'b1; imem_rdata = mem_data(imem_addr);
    @(negedge clk);
    imem_ack = 1'b0;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if ({imem_req, instr_valid} !== 2'b00) begin
        errors++; $display("FAIL halt_idle%0d got req=%b v=%b required 0/0", k, imem_req, instr_valid);
      end
      @(negedge clk);
    end
    checks++;
    if (err !== 1'b0) begin
      errors++; $display("FAIL halt_err_clean got %b required 0", err);
    end
    imem_ack = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    checks++;
    if (err !== 1'b1) begin
      errors++; $display("FAIL err_ack_no_req got %b required 1", err);
    end
  endtask

  task automatic test_async_reset();
    logic [15:0] got;
    logic [31:0] e;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wait_req();
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({imem_req, imem_addr, Instruction, PC_plus_two, instr_valid, err} !==
        {1'b0, 16'h0000, 16'h0800, 16'h0000, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL async_rst got req=%b addr=%h ins=%h pc2=%h v=%b err=%b required 0/0000/0800/0000/0/0",
               imem_req, imem_addr, Instruction, PC_plus_two, instr_valid, err);
    end
    @(negedge clk);
    rst = 1'b0; imem_ack = 1'b1; imem_rdata = 16'h1234;
    @(negedge clk);
    imem_ack = 1'b0;
    checks++;
    if ({err, instr_valid} !== 2'b00) begin
      errors++; $display("FAIL late_ack got err=%b v=%b required 0/0", err, instr_valid);
    end
    serve(16'h0000, 1'b1, got);
    checks++;
    if (got !== 16'h0000) begin
      errors++; $display("FAIL first_addr got %h required 0000", got);
    end
    e = (exp_q.size() == 0) ? 32'hFFFF_FFFF : exp_q.pop_front();
    checks++;
    if ({Instruction, PC_plus_two, instr_valid} !== {e, 1'b1}) begin
      errors++;
      $display("FAIL post_rst_out got %h/%h/%b required %h/%h/1", Instruction, PC_plus_two, instr_valid, e[31:16], e[15:0]);
    end
  endtask

  task automatic test_err_both();
    siic = 1'b1; rti = 1'b1;
    @(negedge clk);
    siic = 1'b0; rti = 1'b0;
    checks++;
    if (err !== 1'b1) begin
      errors++; $display("FAIL err_siic_rti got %b required 1", err);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (err !== 1'b1) begin
      errors++; $display("FAIL err_sticky got %b required 1", err);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_zero_wait();
    test_stall_hold();
    test_redirect_wait();
    test_siic_rti();
    test_wrap();
    test_halt();
    test_async_reset();
    test_err_both();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_leftover got %0d required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have these ports, clock and reset first:
  clk  in  1  system clock; all state updates on rising edge
  rst  in  1  master reset; asynchronous, active-high
  stall  in  1  decode hazard; hold IF/ID contents
  redirect  in  1  branch/jump taken; resolved in decode or execute
  redirect_target  in  16  new PC when redirect=1
  halt  in  1  decode saw HALT; stop fetching
  siic  in  1  decode saw SIIC; trap to 0x0002
  rti  in  1  decode saw RTI; return to EPC
  imem_req  out  1  instruction-memory read request, registered
  imem_addr  out  16  read address, registered
  imem_ack  in  1  memory response valid; data on imem_rdata this cycle
  imem_rdata  in  16  fetched instruction
  Instruction  out  16  IF/ID instruction to decode
  PC_plus_two  out  16  IF/ID PC+2 of Instruction
  instr_valid  out  1  IF/ID holds a real instruction, not a bubble
  err  out  1  protocol/usage error, sticky until reset

Function
REQ-002 SHALL hold a 16-bit PC register; PC+2 arithmetic wraps modulo 2^16 (0xFFFE+2=0x0000).
REQ-003 SHALL implement states ISSUE, WAIT, HALTED.
REQ-004 ISSUE: when hold buffer empty and not halting, SHALL assert imem_req with imem_addr=PC next cycle, then enter WAIT.
REQ-005 WAIT: imem_req and imem_addr SHALL stay stable until the cycle imem_ack=1; max one outstanding request.
REQ-006 imem_ack may arrive in the first cycle imem_req is high; data SHALL be captured at that edge.
REQ-007 Accepted response with stall=0 SHALL load IF/ID: Instruction=imem_rdata, PC_plus_two=PC+2, instr_valid=1; PC<=PC+2; return to ISSUE.
REQ-008 Accepted response with stall=1 SHALL go to a one-entry hold buffer; no new request while buffer full.
REQ-009 When stall falls with buffer full, SHALL move buffer to IF/ID on that edge; buffer empties.
REQ-010 stall=1 with no new data SHALL keep Instruction, PC_plus_two, instr_valid unchanged.
REQ-011 Bubble = Instruction 16'h0800 (NOP), instr_valid=0.
REQ-012 redirect=1 SHALL set PC<=redirect_target, load bubble into IF/ID, clear hold buffer, regardless of stall.
REQ-013 redirect during WAIT SHALL set drop flag: request stays until imem_ack, data discarded, then ISSUE at new PC.
REQ-014 siic=1 SHALL set EPC<=PC_plus_two output, then act as redirect to 16'h0002.
REQ-015 rti=1 SHALL act as redirect to EPC.
REQ-016 Priority: rst > siic/rti > redirect > halt > stall > normal fetch.
REQ-017 halt=1 without redirect SHALL load bubble, drop any outstanding response, issue no new requests, enter HALTED once no request outstanding.
REQ-018 HALTED SHALL be left only by reset; imem_req=0 throughout.
REQ-019 err SHALL set on: imem_ack while imem_req=0; siic and rti both 1; imem_ack with X/Z on imem_rdata.

Reset
REQ-020 rst=1 SHALL immediately force: PC=0x0000, EPC=0x0000, state ISSUE, imem_req=0, imem_addr=0x0000, Instruction=0x0800, PC_plus_two=0x0000, instr_valid=0, hold buffer empty, drop flag clear, err=0.
REQ-021 Reset mid-WAIT SHALL abandon the request; a late imem_ack in the first cycle after reset release SHALL be ignored without err.
REQ-022 First request after reset release SHALL be address 0x0000.

Verification
REQ-023 Zero-wait memory (ack same cycle as req), no stall: addresses 0x0000,0x0002,0x0004 fetched; PC_plus_two 0x0002,0x0004,0x0006; instr_valid=1.
REQ-024 Ack 3 cycles after req, stall=1 on response cycle for 2 cycles: data in hold buffer, no new imem_req, Instruction loaded the cycle after stall falls.
REQ-025 redirect to 0x0100 during WAIT at 0x0010: response for 0x0010 discarded, bubble 0x0800/valid=0, next imem_addr=0x0100.
REQ-026 siic with PC_plus_two=0x0024, later rti: first redirect to 0x0002, EPC=0x0024, rti fetches 0x0024.
REQ-027 halt=1: imem_req stays 0 forever, instr_valid=0; async rst mid-WAIT clears all to reset values without a clk edge; siic+rti together or ack without req sets err=1.
